// File: rtl/viterbi_pkg.sv
// Shared constants and FSM encoding for the K=3 (4-state) Viterbi traceback block.
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int STATE_W    = 2;
  localparam int DEC_W      = 4;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_TRACE = 2'd1,
    ST_EMIT  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/viterbi_traceback_if.sv
// Decision-input and decoded-bit-output streams of the traceback block.
interface viterbi_traceback_if;
  import viterbi_pkg::*;

  // A beat transfers on a rising edge where valid and ready are both high.
  // The source holds valid and its payload stable until that edge, and ready never waits on valid.
  logic               in_valid;
  logic               in_ready;
  logic [DEC_W-1:0]   in_dec;
  logic               in_last;
  logic [STATE_W-1:0] in_best;
  logic               out_valid;
  logic               out_ready;
  logic               out_bit;
  logic               out_last;

  modport slave (
    input  in_valid, in_dec, in_last, in_best, out_ready,
    output in_ready, out_valid, out_bit, out_last
  );

  modport master (
    output in_valid, in_dec, in_last, in_best, out_ready,
    input  in_ready, out_valid, out_bit, out_last
  );

endinterface

// File: rtl/viterbi_tb_mem.sv
// Decision buffer: DEPTH x DEC_W, registered write port, asynchronous read port.
module viterbi_tb_mem
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DEC_W-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DEC_W-1:0]           rd_data
);

  logic [DEC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/viterbi_traceback.sv
// Frame-based Viterbi traceback: buffer survivor decisions, trace back from the best
// end state one step per cycle, then stream the decoded bits oldest first.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  viterbi_traceback_if.slave      bus,
  output logic                    busy,
  output logic                    err_ovf,
  output fsm_state_t              dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fsm_state_t         state, state_next;
  logic [AW-1:0]      wr_ptr, idx, rd;
  logic [LW-1:0]      len;
  logic [STATE_W-1:0] s;
  logic [DEPTH-1:0]   bit_buf;
  logic               emit_rdy;
  logic [DEC_W-1:0]   rd_dec;
  logic               accept, at_cap, frame_end, ovf_hit;
  logic               out_fire, last_fire;

  assign bus.in_ready = (state == ST_FILL);
  assign accept       = bus.in_valid && bus.in_ready;
  assign at_cap       = (wr_ptr == AW'(DEPTH - 1));
  assign frame_end    = accept && (bus.in_last || at_cap);
  assign ovf_hit      = accept && !bus.in_last && at_cap;

  assign bus.out_valid = (state == ST_EMIT) && emit_rdy;
  assign bus.out_last  = bus.out_valid && (LW'(rd) == (len - LW'(1)));
  assign bus.out_bit   = bus.out_valid ? bit_buf[rd] : 1'b0;
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign last_fire     = out_fire && bus.out_last;

  assign busy      = (state != ST_FILL);
  assign dbg_state = state;

  viterbi_tb_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_dec),
    .rd_addr (idx),
    .rd_data (rd_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FILL:  if (frame_end)   state_next = ST_TRACE;
      ST_TRACE: if (idx == '0)   state_next = ST_EMIT;
      ST_EMIT:  if (last_fire)   state_next = ST_FILL;
      default:                   state_next = ST_FILL;
    endcase
  end

  // emit_rdy adds one turnaround cycle between the final traceback step and the first output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      idx      <= '0;
      rd       <= '0;
      len      <= '0;
      s        <= '0;
      emit_rdy <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      err_ovf  <= ovf_hit;
      emit_rdy <= (state == ST_EMIT) && (state_next == ST_EMIT);
      case (state)
        ST_FILL: begin
          if (frame_end) begin
            len    <= LW'(wr_ptr) + LW'(1);
            idx    <= wr_ptr;
            s      <= bus.in_best;
            rd     <= '0;
            wr_ptr <= '0;
          end else if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        ST_TRACE: begin
          s <= {s[0], rd_dec[s]};
          if (idx != '0) idx <= idx - AW'(1);
        end
        ST_EMIT: begin
          if (last_fire)     rd <= '0;
          else if (out_fire) rd <= rd + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_TRACE) bit_buf[idx] <= s[1];
  end

endmodule

// File: doc/viterbi_traceback.md
VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

Interface
REQ-001 Parameter DEPTH, default 16, maximum frame length in trellis steps (power of two, >=2).
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  decision vector on in_dec is valid.
REQ-005 in_ready  out  1  block accepts a decision vector this cycle.
REQ-006 in_dec  in  4  survivor decisions; bit i belongs to trellis state i (K=3, 4 states).
REQ-007 in_last  in  1  final step of frame; qualifies in_best.
REQ-008 in_best  in  2  state with best path metric at frame end.
REQ-009 out_valid  out  1  out_bit is valid.
REQ-010 out_ready  in  1  downstream consumes out_bit this cycle.
REQ-011 out_bit  out  1  decoded information bit, oldest first.
REQ-012 out_last  out  1  marks final decoded bit of frame.
REQ-013 busy  out  1  high whenever the FSM is not in FILL.
REQ-014 err_ovf  out  1  one-cycle pulse on frame-length overflow.

Function
REQ-015 FSM states SHALL be FILL, TRACE and EMIT; in_ready SHALL equal (state==FILL).
REQ-016 Trellis convention: next state = {u, s[1]}; decoded bit of a step = s[1] of the arriving state; predecessor of s = {s[0], dec[s]}.
REQ-017 FILL: each accepted beat SHALL write in_dec to decision buffer at wr_ptr and increment wr_ptr.
REQ-018 On accepted beat with in_last=1, the block SHALL latch len=wr_ptr+1 and s=in_best, then enter TRACE next cycle.
REQ-019 On the DEPTH-th accepted beat without in_last, the block SHALL treat it as last (using in_best) and pulse err_ovf for exactly one cycle.
REQ-020 TRACE SHALL process exactly one step per cycle, index len-1 down to 0: bit_buf[idx]=s[1]; s={s[0], dec[idx][s]}.
REQ-021 TRACE SHALL last exactly len cycles; out_valid SHALL first assert on the (len+1)th rising edge after the edge accepting in_last.
REQ-022 EMIT SHALL present bit_buf[rd], rd = 0..len-1; out_last=1 only when rd==len-1; rd advances only on out_valid&out_ready.
REQ-023 out_bit, out_last and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 After the out_last handshake the FSM SHALL return to FILL with wr_ptr=0; in_ready SHALL be 1 the next cycle.
REQ-025 A one-beat frame (len=1) SHALL produce one bit with out_last=1.
REQ-026 in_valid during TRACE/EMIT SHALL be ignored (no write, no pointer change).

Reset
REQ-027 On rst: state=FILL, wr_ptr=0, rd=0, len=0, s=0; outputs in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0, err_ovf=0.
REQ-028 rst in any state, including mid-TRACE or mid-EMIT, SHALL discard the current frame with no further output beats.
REQ-029 Buffer contents need not be reset.

Structure
REQ-030 Shared package viterbi_pkg SHALL hold NUM_STATES=4, STATE_W=2, DEC_W=4 and the FSM state enumeration.
REQ-031 One sub-module, viterbi_tb_mem (DEPTH x DEC_W, one write and one read port, registered write), SHALL hold decisions; the bit buffer SHALL be a flop array in the top.

Verification
REQ-032 in_dec=4'b0000 x4, in_best=2'b11 on beat 4 -> outputs 0,0,1,1; out_last on 4th; first out_valid 5 edges after last accept.
REQ-033 in_dec=4'b1111 x3, in_best=2'b00 -> outputs 1,0,0; out_last on 3rd.
REQ-034 Case 032 with out_ready low 3 cycles before each beat -> same bits, out_bit stable while stalled, no duplicates or drops.
REQ-035 16 beats in_dec=4'b0000, in_last never set, in_best=2'b00 -> err_ovf pulses once on 16th accept; 16 zero bits; out_last on 16th.
REQ-036 rst asserted during 2nd TRACE cycle of 4-beat frame -> out_valid stays 0; in_ready=1 the cycle after rst deasserts; next 1-beat frame (in_dec=0, in_best=2'b10) outputs single bit 1 with out_last.
